// File: rtl/tx_queue_arbiter_if.sv
// Bus bundle between the per-queue TX FIFOs, the queue arbiter and the TX state machine.
// The master modport is the arbiter's view; slave is the view of the FIFOs/TX engine side.
interface tx_queue_arbiter_if #(
   parameter int NUM_QUEUES = 4
);
   logic [8*NUM_QUEUES-1:0] q_data;
   logic [NUM_QUEUES-1:0]   q_data_start;
   logic [NUM_QUEUES-1:0]   q_data_end;
   logic [NUM_QUEUES-1:0]   q_data_available;
   logic [NUM_QUEUES-1:0]   q_data_read;
   logic [NUM_QUEUES-1:0]   q_retry;
   logic [7:0]              fifo_data;
   logic                    fifo_data_start;
   logic                    fifo_data_end;
   logic                    fifo_data_available;
   logic                    fifo_data_read;
   logic                    fifo_retry;

   modport master (
      input  q_data, q_data_start, q_data_end, q_data_available,
      input  fifo_data_read, fifo_retry,
      output q_data_read, q_retry,
      output fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
   );

   modport slave (
      output q_data, q_data_start, q_data_end, q_data_available,
      output fifo_data_read, fifo_retry,
      input  q_data_read, q_retry,
      input  fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
   );
endinterface

// File: rtl/tx_queue_arbiter.sv
// Frame-granular arbiter sharing one TX state machine FIFO port between NUM_QUEUES queues.
// Define TX_ARB_STRICT_PRIORITY_EN for lowest-index-wins priority; default is round robin.
module tx_queue_arbiter #(
   parameter int NUM_QUEUES = 4,
   parameter int QW         = 2
) (
   input  logic               clock,
   input  logic               reset,
   tx_queue_arbiter_if.master bus,
   output logic               grant_valid,
   output logic [QW-1:0]      grant_id,
   output logic               protocol_error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKED  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [QW-1:0]         grant_id_reg, grant_id_next;
   logic [QW-1:0]         rr_ptr_reg, rr_ptr_next;
   logic                  protocol_error_reg, protocol_error_next;
   logic [QW-1:0]         scan_base;
   logic [QW-1:0]         win_id;
   logic                  win_found;
   int                    scan_idx;
   logic                  locked;
   logic                  frame_done;
   logic [NUM_QUEUES-1:0] sel;
   logic [7:0]            head_data;
   logic                  head_start;
   logic                  head_end;
   logic                  head_available;

   assign locked = (state_reg == LOCKED);

`ifdef TX_ARB_STRICT_PRIORITY_EN
   assign scan_base = '0;
`else
   assign scan_base = rr_ptr_reg;
`endif

   // One-hot select of the locked queue; strobes reach only that queue.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
         assign sel[gi]             = locked && (grant_id_reg == QW'(gi));
         assign bus.q_data_read[gi] = sel[gi] & bus.fifo_data_read;
         assign bus.q_retry[gi]     = sel[gi] & bus.fifo_retry;
      end
   endgenerate

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         scan_idx = (int'(scan_base) + k) % NUM_QUEUES;
         if (!win_found && bus.q_data_available[scan_idx]) begin
            win_found = 1'b1;
            win_id    = QW'(scan_idx);
         end
      end
   end

   always_comb begin
      head_data      = '0;
      head_start     = 1'b0;
      head_end       = 1'b0;
      head_available = 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (sel[i]) begin
            head_data      = bus.q_data[8*i +: 8];
            head_start     = bus.q_data_start[i];
            head_end       = bus.q_data_end[i];
            head_available = bus.q_data_available[i];
         end
      end
   end

   assign bus.fifo_data           = head_data;
   assign bus.fifo_data_start     = head_start;
   assign bus.fifo_data_end       = head_end;
   assign bus.fifo_data_available = head_available;

   // End of frame beats a simultaneous retry: the frame is treated as consumed.
   assign frame_done = bus.fifo_data_read && ((sel & bus.q_data_end) != '0);

   always_comb begin
      state_next          = state_reg;
      grant_id_next       = grant_id_reg;
      rr_ptr_next         = rr_ptr_reg;
      protocol_error_next = protocol_error_reg | (bus.fifo_data_read & ~locked);
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               state_next    = LOCKED;
               grant_id_next = win_id;
            end
         end
         LOCKED: begin
            if (frame_done) begin
               state_next = RELEASE;
`ifdef TX_ARB_STRICT_PRIORITY_EN
               rr_ptr_next = '0;
`else
               rr_ptr_next = (grant_id_reg == QW'(NUM_QUEUES - 1)) ? '0
                                                                   : grant_id_reg + QW'(1);
`endif
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg          <= IDLE;
         grant_id_reg       <= '0;
         rr_ptr_reg         <= '0;
         protocol_error_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         grant_id_reg       <= grant_id_next;
         rr_ptr_reg         <= rr_ptr_next;
         protocol_error_reg <= protocol_error_next;
      end
   end

   assign grant_valid    = locked;
   assign grant_id       = grant_id_reg;
   assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_tx_queue_arbiter.sv
// Directed bench for tx_queue_arbiter: behavioural queue FIFOs plus a simple TX reader.
// Expected values are hand-derived; strict-priority build changes one expected grant order.
module tb_tx_queue_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       protocol_error;

   int vec_count  = 0;
   int miss_count = 0;

   int pos[4];
   int len[4];
   int frames[4];

   int grant_log[$];
   int max_gap;
   bit timed_out;

   tx_queue_arbiter_if #(.NUM_QUEUES(4)) bus();

   tx_queue_arbiter #(.NUM_QUEUES(4), .QW(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .grant_valid    (grant_valid),
      .grant_id       (grant_id),
      .protocol_error (protocol_error)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, required completion before 500000");
      $fatal(1, "bench watchdog expired");
   end

   task automatic refresh_q();
      for (int i = 0; i < 4; i++) begin
         bus.q_data[8*i +: 8]      = 8'((i * 64 + pos[i]) & 255);
         bus.q_data_start[i]       = (frames[i] > 0) && (pos[i] == 0);
         bus.q_data_end[i]         = (frames[i] > 0) && (pos[i] == len[i] - 1);
         bus.q_data_available[i]   = (frames[i] > 0);
      end
   endtask

   task automatic flush_q();
      for (int i = 0; i < 4; i++) begin
         pos[i]    = 0;
         len[i]    = 1;
         frames[i] = 0;
      end
   endtask

   task automatic set_frame(input int q, input int l, input int n);
      pos[q]    = 0;
      len[q]    = l;
      frames[q] = n;
   endtask

   // Advance one clock: queues react to the strobes seen just before the edge.
   task automatic next_cycle();
      logic [3:0] rd;
      logic [3:0] rt;
      rd = bus.q_data_read;
      rt = bus.q_retry;
      @(posedge clock);
      #1;
      if (!reset) begin
         flush_q();
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (rd[i] && pos[i] == len[i] - 1) begin
               pos[i]    = 0;
               frames[i] = frames[i] - 1;
            end else if (rt[i]) begin
               pos[i] = 0;
            end else if (rd[i]) begin
               pos[i] = pos[i] + 1;
            end
         end
      end
      refresh_q();
      @(negedge clock);
   endtask

   // Reads every pending frame as fast as allowed, logging grant order and idle gaps.
   task automatic serve_all(input int budget);
      int  gap;
      bit  prev;
      bit  seen;
      int  pending;
      grant_log.delete();
      max_gap   = 0;
      timed_out = 1'b1;
      gap       = 0;
      prev      = 1'b0;
      seen      = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (grant_valid && !prev) begin
            grant_log.push_back(int'(grant_id));
            $display("grant q%0d at %0t", grant_id, $time);
            if (seen && gap > max_gap) max_gap = gap;
            gap  = 0;
            seen = 1'b1;
         end else if (!grant_valid && seen) begin
            gap++;
         end
         prev = grant_valid;
         bus.fifo_data_read = grant_valid && bus.fifo_data_available;
         #1;
         pending = frames[0] + frames[1] + frames[2] + frames[3];
         if (pending == 0 && !grant_valid) begin
            timed_out = 1'b0;
            bus.fifo_data_read = 1'b0;
            next_cycle();
            break;
         end
         next_cycle();
      end
      bus.fifo_data_read = 1'b0;
   endtask

   task automatic test_reset();
      set_frame(0, 4, 1);
      refresh_q();
      bus.fifo_data_read = 1'b1;
      #1;
      vec_count++;
      if (grant_valid !== 1'b0) begin miss_count++; $display("FAIL rst_grant_valid: observed %0b, required 0", grant_valid); end
      vec_count++;
      if (grant_id !== 2'd0) begin miss_count++; $display("FAIL rst_grant_id: observed %0d, required 0", grant_id); end
      vec_count++;
      if (protocol_error !== 1'b0) begin miss_count++; $display("FAIL rst_protocol_error: observed %0b, required 0", protocol_error); end
      vec_count++;
      if (bus.fifo_data_available !== 1'b0) begin miss_count++; $display("FAIL rst_fifo_available: observed %0b, required 0", bus.fifo_data_available); end
      vec_count++;
      if (bus.q_data_read !== 4'b0000) begin miss_count++; $display("FAIL rst_q_read: observed %b, required 0000", bus.q_data_read); end
      bus.fifo_data_read = 1'b0;
      flush_q();
      refresh_q();
      reset = 1'b1;
      next_cycle();
      #1;
      vec_count++;
      if (grant_valid !== 1'b0) begin miss_count++; $display("FAIL post_rst_idle: observed %0b, required 0", grant_valid); end
      vec_count++;
      if (protocol_error !== 1'b0) begin miss_count++; $display("FAIL post_rst_perr: observed %0b, required 0", protocol_error); end
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      int exp_a[4];
      int exp_b[2];
      int exp_c[2];
      int got;
      exp_a = '{0, 1, 2, 3};
      exp_b = '{1, 2};
`ifdef TX_ARB_STRICT_PRIORITY_EN
      exp_c = '{1, 3};
`else
      exp_c = '{3, 1};
`endif
      for (int i = 0; i < 4; i++) set_frame(i, 4, 1);
      refresh_q();
      serve_all(200);
      vec_count++;
      if (timed_out) begin miss_count++; $display("FAIL rr_all_timeout: observed timeout, required completion"); end
      for (int i = 0; i < 4; i++) begin
         got = (i < grant_log.size()) ? grant_log[i] : -1;
         vec_count++;
         if (got !== exp_a[i]) begin miss_count++; $display("FAIL rr_all_order[%0d]: observed %0d, required %0d", i, got, exp_a[i]); end
      end
      vec_count++;
      if (max_gap !== 2) begin miss_count++; $display("FAIL rr_gap: observed %0d, required 2", max_gap); end

      set_frame(1, 3, 1);
      set_frame(2, 3, 1);
      refresh_q();
      serve_all(200);
      for (int i = 0; i < 2; i++) begin
         got = (i < grant_log.size()) ? grant_log[i] : -1;
         vec_count++;
         if (got !== exp_b[i]) begin miss_count++; $display("FAIL rr_wrap_order[%0d]: observed %0d, required %0d", i, got, exp_b[i]); end
      end

      set_frame(1, 2, 1);
      set_frame(3, 2, 1);
      refresh_q();
      serve_all(200);
      for (int i = 0; i < 2; i++) begin
         got = (i < grant_log.size()) ? grant_log[i] : -1;
         vec_count++;
         if (got !== exp_c[i]) begin miss_count++; $display("FAIL rr_ptr3_order[%0d]: observed %0d, required %0d", i, got, exp_c[i]); end
      end
      $display("test_round_robin done");
   endtask

   task automatic test_single_frame();
      int n      = 0;
      int others = 0;
      bit done   = 1'b0;
      set_frame(1, 64, 1);
      refresh_q();
      #1;
      vec_count++;
      if (grant_valid !== 1'b0 || bus.fifo_data_available !== 1'b0) begin
         miss_count++; $display("FAIL sf_arb_latency: observed valid=%0b avail=%0b, required 0/0", grant_valid, bus.fifo_data_available);
      end
      next_cycle();
      #1;
      vec_count++;
      if (grant_valid !== 1'b1) begin miss_count++; $display("FAIL sf_locked: observed %0b, required 1", grant_valid); end
      vec_count++;
      if (grant_id !== 2'd1) begin miss_count++; $display("FAIL sf_grant_id: observed %0d, required 1", grant_id); end
      vec_count++;
      if (bus.fifo_data_available !== 1'b1) begin miss_count++; $display("FAIL sf_available: observed %0b, required 1", bus.fifo_data_available); end
      for (int c = 0; c < 100 && !done; c++) begin
         bus.fifo_data_read = grant_valid && bus.fifo_data_available;
         #1;
         if (bus.fifo_data_read) begin
            vec_count++;
            if (bus.fifo_data !== 8'(64 + n)) begin miss_count++; $display("FAIL sf_byte[%0d]: observed %0h, required %0h", n, bus.fifo_data, 8'(64 + n)); end
            vec_count++;
            if (bus.fifo_data_start !== (n == 0) || bus.fifo_data_end !== (n == 63)) begin
               miss_count++; $display("FAIL sf_flags[%0d]: observed start=%0b end=%0b, required %0b/%0b", n, bus.fifo_data_start, bus.fifo_data_end, n == 0, n == 63);
            end
            if (bus.q_data_read !== 4'b0010) others++;
            if (bus.fifo_data_end) done = 1'b1;
            n++;
         end
         next_cycle();
      end
      bus.fifo_data_read = 1'b0;
      #1;
      vec_count++;
      if (n !== 64) begin miss_count++; $display("FAIL sf_read_count: observed %0d, required 64", n); end
      vec_count++;
      if (others !== 0) begin miss_count++; $display("FAIL sf_stray_strobes: observed %0d, required 0", others); end
      vec_count++;
      if (grant_valid !== 1'b0 || bus.fifo_data_available !== 1'b0) begin
         miss_count++; $display("FAIL sf_release: observed valid=%0b avail=%0b, required 0/0", grant_valid, bus.fifo_data_available);
      end
      next_cycle();
      #1;
      vec_count++;
      if (grant_valid !== 1'b0 || protocol_error !== 1'b0) begin
         miss_count++; $display("FAIL sf_idle: observed valid=%0b perr=%0b, required 0/0", grant_valid, protocol_error);
      end
      $display("test_single_frame done: %0d bytes", n);
   endtask

   task automatic test_retry();
      int  retries = 0;
      int  bad     = 0;
      int  n       = 0;
      bit  done    = 1'b0;
      set_frame(2, 8, 1);
      refresh_q();
      next_cycle();
      #1;
      vec_count++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
         miss_count++; $display("FAIL rt_grant: observed valid=%0b id=%0d, required 1/2", grant_valid, grant_id);
      end
      for (int c = 0; c < 3; c++) begin
         bus.fifo_data_read = 1'b1;
         #1;
         vec_count++;
         if (bus.fifo_data !== 8'(128 + c)) begin miss_count++; $display("FAIL rt_pre_byte[%0d]: observed %0h, required %0h", c, bus.fifo_data, 8'(128 + c)); end
         next_cycle();
      end
      bus.fifo_data_read = 1'b0;
      bus.fifo_retry     = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         if (bus.q_retry === 4'b0100) retries++;
         if (bus.q_data_read !== 4'b0000 || grant_valid !== 1'b1 || grant_id !== 2'd2) bad++;
         next_cycle();
      end
      bus.fifo_retry = 1'b0;
      vec_count++;
      if (retries !== 16) begin miss_count++; $display("FAIL rt_retry_cycles: observed %0d, required 16", retries); end
      vec_count++;
      if (bad !== 0) begin miss_count++; $display("FAIL rt_hold: observed %0d bad cycles, required 0", bad); end
      for (int c = 0; c < 20 && !done; c++) begin
         bus.fifo_data_read = grant_valid && bus.fifo_data_available;
         #1;
         if (bus.fifo_data_read) begin
            if (n == 0) begin
               vec_count++;
               if (bus.fifo_data_start !== 1'b1 || bus.fifo_data !== 8'd128) begin
                  miss_count++; $display("FAIL rt_resend_start: observed start=%0b data=%0h, required 1/80", bus.fifo_data_start, bus.fifo_data);
               end
            end
            if (bus.q_data_read !== 4'b0100 || grant_id !== 2'd2) bad++;
            if (bus.fifo_data_end) done = 1'b1;
            n++;
         end
         next_cycle();
      end
      bus.fifo_data_read = 1'b0;
      #1;
      vec_count++;
      if (n !== 8 || bad !== 0) begin miss_count++; $display("FAIL rt_resend: observed %0d bytes %0d bad, required 8/0", n, bad); end
      vec_count++;
      if (grant_valid !== 1'b0) begin miss_count++; $display("FAIL rt_release: observed %0b, required 0", grant_valid); end
      next_cycle();
      $display("test_retry done: %0d retry cycles, %0d bytes resent", retries, n);
   endtask

   task automatic test_retry_end();
      set_frame(2, 2, 1);
      refresh_q();
      next_cycle();
      bus.fifo_data_read = 1'b1;
      #1;
      next_cycle();
      bus.fifo_retry = 1'b1;
      #1;
      vec_count++;
      if (bus.q_retry !== 4'b0100 || bus.q_data_read !== 4'b0100 || bus.fifo_data_end !== 1'b1) begin
         miss_count++; $display("FAIL re_same_cycle: observed retry=%b read=%b end=%0b, required 0100/0100/1", bus.q_retry, bus.q_data_read, bus.fifo_data_end);
      end
      next_cycle();
      bus.fifo_data_read = 1'b0;
      bus.fifo_retry     = 1'b0;
      #1;
      vec_count++;
      if (grant_valid !== 1'b0 || bus.fifo_data_available !== 1'b0) begin
         miss_count++; $display("FAIL re_release: observed valid=%0b avail=%0b, required 0/0", grant_valid, bus.fifo_data_available);
      end
      next_cycle();
      next_cycle();
      $display("test_retry_end done");
   endtask

   task automatic test_protocol_error();
      #1;
      vec_count++;
      if (protocol_error !== 1'b0) begin miss_count++; $display("FAIL pe_clear_before: observed %0b, required 0", protocol_error); end
      bus.fifo_data_read = 1'b1;
      bus.fifo_retry     = 1'b1;
      #1;
      vec_count++;
      if (bus.q_data_read !== 4'b0000 || bus.q_retry !== 4'b0000) begin
         miss_count++; $display("FAIL pe_no_strobe: observed read=%b retry=%b, required 0000/0000", bus.q_data_read, bus.q_retry);
      end
      next_cycle();
      bus.fifo_data_read = 1'b0;
      bus.fifo_retry     = 1'b0;
      #1;
      vec_count++;
      if (protocol_error !== 1'b1) begin miss_count++; $display("FAIL pe_set: observed %0b, required 1", protocol_error); end
      for (int c = 0; c < 3; c++) next_cycle();
      #1;
      vec_count++;
      if (protocol_error !== 1'b1) begin miss_count++; $display("FAIL pe_sticky: observed %0b, required 1", protocol_error); end
      $display("test_protocol_error done");
   endtask

   task automatic test_reset_mid_frame();
      set_frame(3, 16, 1);
      refresh_q();
      next_cycle();
      #1;
      vec_count++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
         miss_count++; $display("FAIL rm_grant: observed valid=%0b id=%0d, required 1/3", grant_valid, grant_id);
      end
      for (int c = 0; c < 5; c++) begin
         bus.fifo_data_read = 1'b1;
         #1;
         next_cycle();
      end
      reset = 1'b0;
      #1;
      vec_count++;
      if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
         miss_count++; $display("FAIL rm_grant_cleared: observed valid=%0b id=%0d, required 0/0", grant_valid, grant_id);
      end
      vec_count++;
      if (bus.fifo_data_available !== 1'b0 || bus.fifo_data !== 8'd0 || bus.fifo_data_start !== 1'b0 || bus.fifo_data_end !== 1'b0) begin
         miss_count++; $display("FAIL rm_fifo_outputs: observed avail=%0b data=%0h, required 0/00", bus.fifo_data_available, bus.fifo_data);
      end
      vec_count++;
      if (bus.q_data_read !== 4'b0000 || bus.q_retry !== 4'b0000) begin
         miss_count++; $display("FAIL rm_q_strobes: observed read=%b retry=%b, required 0000/0000", bus.q_data_read, bus.q_retry);
      end
      vec_count++;
      if (protocol_error !== 1'b0) begin miss_count++; $display("FAIL rm_perr_cleared: observed %0b, required 0", protocol_error); end
      bus.fifo_data_read = 1'b0;
      flush_q();
      refresh_q();
      next_cycle();
      reset = 1'b1;
      next_cycle();
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_first_after_reset();
      int got;
      set_frame(3, 4, 1);
      set_frame(0, 4, 1);
      refresh_q();
      serve_all(200);
      vec_count++;
      if (timed_out) begin miss_count++; $display("FAIL far_timeout: observed timeout, required completion"); end
      got = (grant_log.size() > 0) ? grant_log[0] : -1;
      vec_count++;
      if (got !== 0) begin miss_count++; $display("FAIL far_first: observed %0d, required 0", got); end
      got = (grant_log.size() > 1) ? grant_log[1] : -1;
      vec_count++;
      if (got !== 3) begin miss_count++; $display("FAIL far_second: observed %0d, required 3", got); end
      $display("test_first_after_reset done");
   endtask

   initial begin
      reset              = 1'b0;
      bus.fifo_data_read = 1'b0;
      bus.fifo_retry     = 1'b0;
      flush_q();
      refresh_q();
      @(negedge clock);
      test_reset();
      test_round_robin();
      test_single_frame();
      test_retry();
      test_retry_end();
      test_protocol_error();
      test_reset_mid_frame();
      test_first_after_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
